// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types: PC/ADDR2 mux selects, word width and sign-extension helper.
package lc3_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_BUS  = 2'b01,
        PC_ADDR = 2'b10,
        PC_HOLD = 2'b11
    } pcmux_t;

    typedef enum logic [1:0] {
        A2_ZERO  = 2'b00,
        A2_OFF6  = 2'b01,
        A2_OFF9  = 2'b10,
        A2_OFF11 = 2'b11
    } addr2mux_t;

    // Replicates bit 'msb' of 'value' into every higher bit position.
    function automatic logic [WORD_W-1:0] sext16(input logic [WORD_W-1:0] value,
                                                 input int msb);
        logic [WORD_W-1:0] result;
        result = value;
        for (int i = 0; i < WORD_W; i++) begin
            if (i > msb) begin
                result[i] = value[msb];
            end else begin
                result[i] = value[i];
            end
        end
        return result;
    endfunction

    // Branch condition: any IR mask bit that matches a set condition flag.
    function automatic logic ben_eval(input logic [2:0] nzp_mask,
                                      input logic n, input logic z, input logic p);
        return (nzp_mask[2] & n) | (nzp_mask[1] & z) | (nzp_mask[0] & p);
    endfunction

endpackage

// File: rtl/addr_adder.sv
// ADDR1/ADDR2 muxes and effective-address adder; purely combinational so the
// MARMUX path can reuse it standalone.
module addr_adder
    import lc3_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] sr1_out,
    input  logic [10:0]       ir_off,
    input  logic              addr1mux,
    input  logic [1:0]        addr2mux,
    output logic [WORD_W-1:0] addr_out
);

    logic [WORD_W-1:0] addr1_s;
    logic [WORD_W-1:0] addr2_s;
    logic [WORD_W-1:0] ir_word_s;

    assign ir_word_s = {5'b00000, ir_off};

    // ADDR1 base select: PC or register-file operand.
    always_comb begin
        addr1_s = pc;
        if (addr1mux) begin
            addr1_s = sr1_out;
        end else begin
            addr1_s = pc;
        end
    end

    // ADDR2 offset select with field-width dependent sign extension.
    always_comb begin
        addr2_s = 16'h0000;
        case (addr2mux_t'(addr2mux))
            A2_ZERO:  addr2_s = 16'h0000;
            A2_OFF6:  addr2_s = sext16(ir_word_s, 5);
            A2_OFF9:  addr2_s = sext16(ir_word_s, 8);
            A2_OFF11: addr2_s = sext16(ir_word_s, 10);
            default:  addr2_s = 16'h0000;
        endcase
    end

    // Carry out of bit 15 is intentionally dropped (modulo 2^16 addressing).
    assign addr_out = addr1_s + addr2_s;

endmodule

// File: rtl/pc_branch_unit.sv
// LC-3 PC register, PCMUX, BEN register and effective-address adder, sitting
// just downstream of the NZP condition-code register.
module pc_branch_unit
    import lc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
)(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Bus,
    input  logic [15:0] IR,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic [15:0] SR1_OUT,
    input  logic        LD_BEN,
    input  logic        LD_PC,
    input  logic [1:0]  PCMUX,
    input  logic        ADDR1MUX,
    input  logic [1:0]  ADDR2MUX,
    output logic        BEN,
    output logic [15:0] PC,
    output logic [15:0] ADDR_OUT
);

    logic [WORD_W-1:0] pc_r;
    logic              ben_r;
    logic [WORD_W-1:0] pc_next_s;
    logic              ben_next_s;
    logic [WORD_W-1:0] addr_out_s;
    logic              unused_opcode_s;

    // Opcode bits are decoded by the control FSM, not here.
    assign unused_opcode_s = ^IR[15:12];

    addr_adder u_addr_adder (
        .pc       (pc_r),
        .sr1_out  (SR1_OUT),
        .ir_off   (IR[10:0]),
        .addr1mux (ADDR1MUX),
        .addr2mux (ADDR2MUX),
        .addr_out (addr_out_s)
    );

    // PC next-value selection; reserved encoding holds the current PC.
    always_comb begin
        pc_next_s = pc_r;
        if (LD_PC) begin
            case (pcmux_t'(PCMUX))
                PC_INC:  pc_next_s = pc_r + 16'h0001;
                PC_BUS:  pc_next_s = Bus;
                PC_ADDR: pc_next_s = addr_out_s;
                PC_HOLD: pc_next_s = pc_r;
                default: pc_next_s = pc_r;
            endcase
        end else begin
            pc_next_s = pc_r;
        end
    end

    // BEN samples the pre-edge flag levels, so a same-edge CC update is not seen.
    always_comb begin
        ben_next_s = ben_r;
        if (LD_BEN) begin
            ben_next_s = ben_eval(IR[11:9], n, z, p);
        end else begin
            ben_next_s = ben_r;
        end
    end

    // State registers; reset wins over any same-cycle load.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_r  <= RESET_PC;
            ben_r <= 1'b0;
        end else begin
            pc_r  <= pc_next_s;
            ben_r <= ben_next_s;
        end
    end

    assign PC       = pc_r;
    assign BEN      = ben_r;
    assign ADDR_OUT = addr_out_s;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit: reset, PC increment/load/hold,
// BEN evaluation and effective-address generation.
module tb_pc_branch_unit;

    logic        Clk;
    logic        Reset;
    logic [15:0] Bus;
    logic [15:0] IR;
    logic        n;
    logic        z;
    logic        p;
    logic [15:0] SR1_OUT;
    logic        LD_BEN;
    logic        LD_PC;
    logic [1:0]  PCMUX;
    logic        ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic        BEN;
    logic [15:0] PC;
    logic [15:0] ADDR_OUT;

    int n_compared;
    int n_mismatched;

    pc_branch_unit #(.RESET_PC(16'h0000)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Bus      (Bus),
        .IR       (IR),
        .n        (n),
        .z        (z),
        .p        (p),
        .SR1_OUT  (SR1_OUT),
        .LD_BEN   (LD_BEN),
        .LD_PC    (LD_PC),
        .PCMUX    (PCMUX),
        .ADDR1MUX (ADDR1MUX),
        .ADDR2MUX (ADDR2MUX),
        .BEN      (BEN),
        .PC       (PC),
        .ADDR_OUT (ADDR_OUT)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        @(negedge Clk);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        Reset = 1'b0; Bus = 16'hBEEF; IR = 16'h0E00; n = 1'b1; z = 1'b1; p = 1'b1;
        SR1_OUT = 16'h0000; LD_BEN = 1'b1; LD_PC = 1'b1; PCMUX = 2'b01;
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b00;

        // Reset overrides pending PC/BEN loads
        step(); step();
        check("reset_pc", PC, 16'h0000);
        check("reset_ben", {15'd0, BEN}, 16'h0000);
        check("reset_addr", ADDR_OUT, 16'h0000);
        Reset = 1'b1; LD_PC = 1'b0; LD_BEN = 1'b0;
        step();
        check("post_reset_pc", PC, 16'h0000);
        check("post_reset_ben", {15'd0, BEN}, 16'h0000);

        // Increment wrap
        LD_PC = 1'b1; PCMUX = 2'b01; Bus = 16'hFFFE;
        step();
        check("load_bus", PC, 16'hFFFE);
        PCMUX = 2'b00;
        step();
        check("inc_ffff", PC, 16'hFFFF);
        step();
        check("inc_wrap", PC, 16'h0000);
        LD_PC = 1'b0; PCMUX = 2'b01; Bus = 16'h1111;
        step();
        check("ld_pc_low_hold", PC, 16'h0000);
        LD_PC = 1'b1; Bus = 16'h2222;
        step();
        PCMUX = 2'b11;
        step();
        check("pcmux_reserved_hold", PC, 16'h2222);
        LD_PC = 1'b0;

        // BEN evaluation
        IR = 16'h0A05; n = 1'b0; z = 1'b1; p = 1'b0; LD_BEN = 1'b1;
        step();
        check("ben_brnp_z", {15'd0, BEN}, 16'h0000);
        n = 1'b1; z = 1'b0;
        step();
        check("ben_brnp_n", {15'd0, BEN}, 16'h0001);
        LD_BEN = 1'b0; n = 1'b0;
        step();
        check("ben_hold", {15'd0, BEN}, 16'h0001);
        LD_BEN = 1'b1; IR = 16'h01FF; n = 1'b1; z = 1'b1; p = 1'b1;
        step();
        check("ben_mask_zero", {15'd0, BEN}, 16'h0000);
        IR = 16'h0400; n = 1'b0; z = 1'b1; p = 1'b0;
        step();
        check("ben_brz_z", {15'd0, BEN}, 16'h0001);
        IR = 16'h0E00; z = 1'b0;
        step();
        check("ben_flags_zero", {15'd0, BEN}, 16'h0000);
        LD_BEN = 1'b0;

        // Branch target with negative offset9
        LD_PC = 1'b1; PCMUX = 2'b01; Bus = 16'h3005;
        step();
        LD_PC = 1'b0; IR = 16'h0FFD; ADDR1MUX = 1'b0; ADDR2MUX = 2'b10;
        settle();
        check("addr_off9_neg", ADDR_OUT, 16'h3002);
        LD_PC = 1'b1; PCMUX = 2'b10;
        step();
        check("pc_from_addr", PC, 16'h3002);
        LD_PC = 1'b0; ADDR2MUX = 2'b00;
        settle();
        check("addr_zero_off", ADDR_OUT, 16'h3002);

        // SR1-based addressing
        SR1_OUT = 16'h4000; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; IR = 16'h003F;
        settle();
        check("addr_off6_neg", ADDR_OUT, 16'h3FFF);
        IR = 16'h001F;
        settle();
        check("addr_off6_pos", ADDR_OUT, 16'h401F);
        ADDR2MUX = 2'b11; IR = 16'h0400;
        settle();
        check("addr_off11_neg", ADDR_OUT, 16'h3C00);
        ADDR2MUX = 2'b10; IR = 16'h0100;
        settle();
        check("addr_off9_sr1", ADDR_OUT, 16'h3F00);
        SR1_OUT = 16'hFFFF; ADDR2MUX = 2'b01; IR = 16'h0001;
        settle();
        check("addr_carry_drop", ADDR_OUT, 16'h0000);

        // Simultaneous events, first under reset then without
        Reset = 1'b0; LD_PC = 1'b1; PCMUX = 2'b01; Bus = 16'h1234;
        LD_BEN = 1'b1; IR = 16'h0E00; n = 1'b0; z = 1'b0; p = 1'b1;
        step();
        check("simul_reset_pc", PC, 16'h0000);
        check("simul_reset_ben", {15'd0, BEN}, 16'h0000);
        Reset = 1'b1;
        step();
        check("simul_pc", PC, 16'h1234);
        check("simul_ben", {15'd0, BEN}, 16'h0001);

        // ADDR_OUT follows the registered PC, not the next PC
        LD_BEN = 1'b0; ADDR1MUX = 1'b0; ADDR2MUX = 2'b01; IR = 16'h0E01; PCMUX = 2'b00;
        settle();
        check("addr_cur_pc", ADDR_OUT, 16'h1235);
        step();
        check("inc_pc", PC, 16'h1235);
        check("addr_after_inc", ADDR_OUT, 16'h1236);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Datapath stage directly downstream of the NZP condition-code register in the LC-3 datapath.
- Consumes the latched n/z/p flags and the IR branch mask (IR[11:9]) into a registered BEN bit for the control FSM.
- Also owns the PC register, the PCMUX and the ADDR1/ADDR2 effective-address adder.
- The adder output also feeds MARMUX and the bus gate elsewhere.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-low reset.
Bus  input  16  shared datapath bus (PCMUX source).
IR  input  16  current instruction register contents.
n  input  1  negative flag from the condition-code register.
z  input  1  zero flag from the condition-code register.
p  input  1  positive flag from the condition-code register.
SR1_OUT  input  16  register-file SR1 read data (ADDR1MUX source).
LD_BEN  input  1  load enable for the BEN register.
LD_PC  input  1  load enable for the PC register.
PCMUX  input  2  PC next-value select.
ADDR1MUX  input  1  0 = PC, 1 = SR1_OUT.
ADDR2MUX  input  2  adder offset select.
BEN  output  1  registered branch-enable to the control FSM.
PC  output  16  current program counter.
ADDR_OUT  output  16  combinational effective-address adder result.

Behaviour:
- Reset: when Reset==0 at a rising edge, PC <= RESET_PC and BEN <= 0. Reset overrides LD_PC and LD_BEN in the same cycle. Reset asserted mid-instruction discards any pending load.
- BEN: at a rising edge with LD_BEN==1, BEN <= (IR[11]&n) | (IR[10]&z) | (IR[9]&p). Otherwise BEN holds. Latency is one cycle: BEN is valid the cycle after LD_BEN.
- n/z/p are sampled as levels at the edge. If the condition-code register updates on the same edge, BEN sees the pre-update flags.
- IR[11:9]==000 yields BEN=0 regardless of flags. All flags 0 (pre-first-load) yields BEN=0.
- ADDR2MUX (combinational):
  - 00 -> 16'h0000
  - 01 -> sign-extend IR[5:0]
  - 10 -> sign-extend IR[8:0]
  - 11 -> sign-extend IR[10:0]
- ADDR1 source is PC (ADDR1MUX=0) or SR1_OUT (ADDR1MUX=1).
- ADDR_OUT = ADDR1 + ADDR2, modulo 2^16. Carry is discarded; there is no overflow flag.
- ADDR_OUT uses the current registered PC, not the next PC.
- PC: at a rising edge with LD_PC==1 and Reset==1:
  - PCMUX=00 -> PC+1. 16'hFFFF wraps to 16'h0000.
  - PCMUX=01 -> Bus.
  - PCMUX=10 -> ADDR_OUT.
  - PCMUX=11 -> PC unchanged (reserved).
- LD_PC==0: PC holds regardless of PCMUX.
- LD_PC and LD_BEN are independent. Both may assert in the same cycle, and BEN is computed from the same-cycle IR and flags.
- No X propagation: all outputs are defined from the first post-reset cycle.

Decomposition:
- Shared package lc3_pkg:
  - pcmux_t enum: PC_INC, PC_BUS, PC_ADDR, PC_HOLD.
  - addr2mux_t enum: A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11.
  - Generic 16-bit sign-extend function.
  - WORD_W = 16 constant.
- One combinational sub-module: addr_adder, containing the ADDR1/ADDR2 muxes and the adder. It is reused standalone by the MARMUX path.
- PC and BEN registers stay in pc_branch_unit.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with LD_PC=1, PCMUX=01, Bus=16'hBEEF -> PC==16'h0000 and BEN==0 after release.
- Increment wrap: load PC=16'hFFFE via Bus, then 2 cycles of LD_PC=1, PCMUX=00 -> PC goes 16'hFFFF, then 16'h0000.
- Branch taken/not taken:
  - IR=16'h0A05 (BRnp), flags n=0 z=1 p=0, LD_BEN=1 -> BEN==0.
  - Same IR with n=1 -> BEN==1 next cycle.
  - IR[11:9]=000 with n=z=p=1 -> BEN==0.
- Branch target, negative offset: PC=16'h3005, IR=16'h0FFD (offset9=-3), ADDR1MUX=0, ADDR2MUX=10 -> ADDR_OUT==16'h3002. With LD_PC=1, PCMUX=10 -> PC==16'h3002 next cycle.
- JSRR/LDR path: SR1_OUT=16'h4000, ADDR1MUX=1.
  - ADDR2MUX=01, IR[5:0]=6'h3F -> ADDR_OUT==16'h3FFF.
  - ADDR2MUX=11, IR[10:0]=11'h400 -> ADDR_OUT==16'h3C00.
- Simultaneous events: LD_PC=1 (PCMUX=01, Bus=16'h1234), LD_BEN=1 (IR=16'h0E00, p=1), and Reset=0 in the same cycle -> PC==16'h0000, BEN==0. Repeat with Reset=1 -> PC==16'h1234, BEN==1.
